mem_store_buffer: RTL and testbench
===================================

# mem_store_buffer

Parametrised post-commit store buffer between the memory-access stage and the data-side bus. Accepts byte-enabled stores from the MEM stage and retires them in program order over a request/acknowledge write port, so a store does not stall the pipeline waiting on the bus. It flags loads that overlap still-buffered stores and can optionally forward whole-coverage hits. It generalises the fixed one-deep, word-wide store path of the current MEM stage to configurable depth and data width.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8. Derived: SEL_W = DATA_W/8 and OFF = log2(SEL_W).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  store presented by the MEM stage.
- st_addr  in  ADDR_W  store address; bits [OFF-1:0] are ignored.
- st_wdata  in  DATA_W  store data, already lane-aligned.
- st_sel  in  SEL_W  byte enables; must be nonzero when st_valid.
- st_ready  out  1  buffer can accept a store.
- ld_valid  in  1  load presented for the hazard check.
- ld_addr  in  ADDR_W  load address.
- ld_sel  in  SEL_W  load byte enables.
- ld_conflict  out  1  load must stall.
- ld_fwd_hit  out  1  load is satisfied from the buffer.
- ld_fwd_data  out  DATA_W  forwarded data.
- bus_wr_req  out  1  head entry is valid and offered to the bus.
- bus_addr  out  ADDR_W  head address; low OFF bits are 0.
- bus_wdata  out  DATA_W  head data.
- bus_sel  out  SEL_W  head byte enables.
- bus_wr_ack  in  1  bus accepts the head entry this cycle.
- empty  out  1  no valid entries; used for SYNC and for uncached ordering.
- count  out  log2(DEPTH)+1  number of valid entries.

## Operation

- **Storage:** circular FIFO indexed by wr_ptr and rd_ptr, each log2(DEPTH) bits wide and wrapping naturally. A count register tracks occupancy; full is count==DEPTH.
- **Enqueue:** when st_valid && st_ready, the entry at wr_ptr is written with {addr with low OFF bits cleared, wdata, sel}, and wr_ptr is incremented.
- **st_ready:** equals !full. It does not depend on bus_wr_ack, so a full buffer rejects a store even in a cycle that pops an entry.
- **Dequeue:** when bus_wr_req && bus_wr_ack, the entry is popped and rd_ptr is incremented.
  - bus_wr_req = !empty.
  - bus_addr, bus_wdata and bus_sel come from the entry at rd_ptr.
  - These outputs stay stable until acknowledged.
  - bus_wr_ack while bus_wr_req=0 is ignored.
- **Simultaneous enqueue and dequeue:** count is unchanged and both pointers advance.
- **Load check:**
  - A valid entry overlaps the load when its word address equals ld_addr[ADDR_W-1:OFF] and (entry sel & ld_sel) != 0.
  - All valid entries take part, including a head being acknowledged in the same cycle.
  - A store being enqueued in the same cycle is not checked. The pipeline never presents a load and a store together.
- **Without forwarding:** ld_conflict = ld_valid && (any overlap).
- **Store order:** buffered stores reach the bus strictly in enqueue order. Same-word stores are never merged.

## Timing

- **Reset values:** pointers 0, count 0, all entries cleared. This gives st_ready=1, empty=1, bus_wr_req=0, bus_addr/bus_wdata/bus_sel=0, ld_conflict=0, ld_fwd_hit=0 and ld_fwd_data=0.
- **Reset mid-operation:** any pending entries are discarded and bus_wr_req drops immediately, without waiting for a clock edge.
- **Enqueue-to-request latency:** a store accepted at edge N raises bus_wr_req after edge N when the buffer was empty. It is also visible to the load check from the cycle after edge N.
- **Ack pacing:** with ack held high, one entry drains per cycle.
- **Combinational outputs:** ld_conflict, ld_fwd_hit and ld_fwd_data depend combinationally on the ld_* inputs and registered state. st_ready, empty and count are purely registered state.

## Configuration

- **STORE_BUF_FWD_EN defined:**
  - Among overlapping entries, the newest one (nearest to wr_ptr-1, walking back to rd_ptr) is found.
  - If its sel covers every bit of ld_sel: ld_fwd_hit=1, ld_fwd_data = that entry's data, ld_conflict=0.
  - Otherwise: ld_conflict=1, ld_fwd_hit=0.
  - With no overlap, both outputs are 0.
- **Not defined:** ld_fwd_hit and ld_fwd_data are tied to 0, and every overlap raises ld_conflict.

## Test plan

- **Reset and fill:** reset, then 4 stores (0x100, 0x104, 0x108, 0x10C; sel 4'hF) with bus_wr_ack=0 → count=4 and st_ready=0. A 5th store is rejected and count stays 4.
- **In-order drain:** from the full state, hold ack=1 → bus_addr sequence is 0x100, 0x104, 0x108, 0x10C on consecutive cycles. Then empty=1 and bus_wr_req=0.
- **Pointer wrap:** 10 stores interleaved with single acks → every bus beat matches its enqueued {addr, data, sel} in order. count never exceeds 4.
- **Conflict (no macro):**
  - Buffer holds {0x200, 0xAABBCCDD, 4'b0011}; load 0x202 with sel 4'b1100 → ld_conflict=0.
  - Load 0x201 with sel 4'b0010 → ld_conflict=1.
- **Forwarding (macro set):**
  - Stores {0x300, 0x11111111, 4'hF} then {0x300, 0x22220000, 4'b1100}; load 0x300 with sel 4'b1100 → ld_fwd_hit=1, ld_fwd_data=0x22220000.
  - Same buffer, load sel 4'b0110 → ld_conflict=1.
- **Async reset mid-drain:** assert rst between edges while bus_wr_req=1 → bus_wr_req=0 and count=0 immediately. The first post-reset store is offered at bus_addr with its own data.

Source files
------------

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: in-order post-commit store FIFO with load overlap check; optional forwarding under STORE_BUF_FWD_EN
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int SEL_W = DATA_W / 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [SEL_W-1:0]  st_sel,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [SEL_W-1:0]  ld_sel,
    output logic              ld_conflict,
    output logic              ld_fwd_hit,
    output logic [DATA_W-1:0] ld_fwd_data,
    output logic              bus_wr_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [SEL_W-1:0]  bus_sel,
    input  logic              bus_wr_ack,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(SEL_W - 1);

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [SEL_W-1:0]  ent_sel  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH-1:0]  overlap;
    logic              push, pop;

    assign empty      = count == '0;
    assign st_ready   = count != CNT_W'(DEPTH);
    assign bus_wr_req = !empty;
    assign push       = st_valid && st_ready;
    assign pop        = bus_wr_req && bus_wr_ack;
    assign bus_addr   = ent_addr[rd_ptr];
    assign bus_wdata  = ent_data[rd_ptr];
    assign bus_sel    = ent_sel[rd_ptr];

    // pointer and occupancy update; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    // entry storage; addresses are kept word-aligned so the bus sees clean beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_sel[i]  <= '0;
            end
        end else if (push) begin
            ent_addr[wr_ptr] <= st_addr & ADDR_MASK;
            ent_data[wr_ptr] <= st_wdata;
            ent_sel[wr_ptr]  <= st_sel;
        end
    end

    // an entry overlaps when it is live, hits the same word and shares a byte lane
    always_comb begin
        overlap = '0;
        for (int i = 0; i < DEPTH; i++)
            overlap[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count) && (ent_addr[i] == (ld_addr & ADDR_MASK)) && |(ent_sel[i] & ld_sel);
    end

`ifdef STORE_BUF_FWD_EN
    logic [PTR_W-1:0] new_idx, scan_idx;
    logic             found, covered;

    // walk back from the newest entry to find the youngest overlapping store
    always_comb begin
        found    = 1'b0;
        new_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = wr_ptr - PTR_W'(k + 1);
            if (!found && overlap[scan_idx]) begin
                found   = 1'b1;
                new_idx = scan_idx;
            end
        end
    end

    assign covered     = (ent_sel[new_idx] & ld_sel) == ld_sel;
    assign ld_fwd_hit  = ld_valid && found && covered;
    assign ld_conflict = ld_valid && found && !covered;
    assign ld_fwd_data = ld_fwd_hit ? ent_data[new_idx] : '0;
`else
    assign ld_conflict = ld_valid && |overlap;
    assign ld_fwd_hit  = 1'b0;
    assign ld_fwd_data = '0;
`endif
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed checks of fill, drain, wrap, load hazard/forwarding and async reset
module tb_mem_store_buffer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        st_valid = 1'b0, ld_valid = 1'b0, bus_wr_ack = 1'b0;
    logic [31:0] st_addr = '0, st_wdata = '0, ld_addr = '0;
    logic [3:0]  st_sel = '0, ld_sel = '0;
    logic        st_ready, ld_conflict, ld_fwd_hit, bus_wr_req, empty;
    logic [31:0] ld_fwd_data, bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [2:0]  count;
    int          total = 0, bad = 0;
    logic [31:0] qa[$], qd[$];
    logic [3:0]  qs[$];
    int          sz;

    mem_store_buffer dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_sel(st_sel), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sel(ld_sel),
        .ld_conflict(ld_conflict), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
        .bus_wr_req(bus_wr_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_wr_ack(bus_wr_ack), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        st_valid = 1'b1; st_addr = a; st_wdata = d; st_sel = s;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] s);
        ld_valid = 1'b1; ld_addr = a; ld_sel = s;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_ready", st_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_req", bus_wr_req, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_sel", bus_sel, 0);
        chk("rst_conf", ld_conflict, 0);
        chk("rst_hit", ld_fwd_hit, 0);
        chk("rst_fdata", ld_fwd_data, 0);

        for (int i = 0; i < 4; i++) push(32'h100 + 4 * i, 32'hD0 + i, 4'hF);
        chk("fill_count", count, 4);
        chk("fill_ready", st_ready, 0);
        chk("fill_req", bus_wr_req, 1);
        push(32'h110, 32'hDEAD, 4'hF);
        chk("fill_reject", count, 4);
        chk("fill_head_stable", bus_addr, 32'h100);

        bus_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", bus_addr, 32'h100 + 4 * i);
            chk("drain_data", bus_wdata, 32'hD0 + i);
            tick();
        end
        bus_wr_ack = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_req", bus_wr_req, 0);

        for (int i = 0; i < 10; i++) begin
            st_valid = 1'b1; st_addr = 32'h500 + 4 * i; st_wdata = 32'hA5000000 | i; st_sel = 4'(i % 15 + 1);
            bus_wr_ack = (i % 3 != 0);
            #1;
            sz = qa.size();
            chk("wrap_count", count, sz);
            chk("wrap_ready", st_ready, sz < 4);
            if (sz > 0) begin
                chk("wrap_addr", bus_addr, qa[0]);
                chk("wrap_data", bus_wdata, qd[0]);
                chk("wrap_sel", bus_sel, qs[0]);
            end
            tick();
            if (bus_wr_ack && sz > 0) begin
                void'(qa.pop_front()); void'(qd.pop_front()); void'(qs.pop_front());
            end
            if (sz < 4) begin
                qa.push_back(st_addr); qd.push_back(st_wdata); qs.push_back(st_sel);
            end
        end
        st_valid = 1'b0;
        bus_wr_ack = 1'b1;
        for (int n = 0; n < 8 && qa.size() > 0; n++) begin
            chk("wrap_dr_addr", bus_addr, qa[0]);
            chk("wrap_dr_data", bus_wdata, qd[0]);
            chk("wrap_dr_sel", bus_sel, qs[0]);
            tick();
            void'(qa.pop_front()); void'(qd.pop_front()); void'(qs.pop_front());
        end
        bus_wr_ack = 1'b0;
        chk("wrap_empty", empty, 1);

        for (int i = 0; i < 4; i++) push(32'h100 + 4 * i, 32'hE0 + i, 4'hF);
        bus_wr_ack = 1'b1;
        push(32'h110, 32'hBEEF, 4'hF);
        chk("full_pop_reject", count, 3);
        chk("full_pop_head", bus_addr, 32'h104);
        tick();
        tick();
        chk("full_pop_last", bus_addr, 32'h10C);
        tick();
        chk("full_pop_empty", empty, 1);
        bus_wr_ack = 1'b0;

        push(32'h200, 32'hAABBCCDD, 4'b0011);
        load(32'h202, 4'b1100);
        chk("conf_disjoint", ld_conflict, 0);
        chk("conf_disjoint_hit", ld_fwd_hit, 0);
        load(32'h204, 4'b0011);
        chk("conf_other_word", ld_conflict, 0);
        load(32'h201, 4'b0010);
`ifdef STORE_BUF_FWD_EN
        chk("conf_lane_conf", ld_conflict, 0);
        chk("conf_lane_hit", ld_fwd_hit, 1);
        chk("conf_lane_data", ld_fwd_data, 32'hAABBCCDD);
`else
        chk("conf_lane_conf", ld_conflict, 1);
        chk("conf_lane_hit", ld_fwd_hit, 0);
`endif
        ld_valid = 1'b0;
        #1;
        chk("conf_novalid", ld_conflict, 0);
        bus_wr_ack = 1'b1;
        tick();
        bus_wr_ack = 1'b0;

        push(32'h300, 32'h11111111, 4'hF);
        push(32'h300, 32'h22220000, 4'b1100);
        load(32'h300, 4'b1100);
`ifdef STORE_BUF_FWD_EN
        chk("fwd_new_hit", ld_fwd_hit, 1);
        chk("fwd_new_data", ld_fwd_data, 32'h22220000);
        chk("fwd_new_conf", ld_conflict, 0);
        load(32'h300, 4'b0001);
        chk("fwd_old_hit", ld_fwd_hit, 1);
        chk("fwd_old_data", ld_fwd_data, 32'h11111111);
`else
        chk("fwd_new_hit", ld_fwd_hit, 0);
        chk("fwd_new_data", ld_fwd_data, 0);
        chk("fwd_new_conf", ld_conflict, 1);
`endif
        load(32'h300, 4'b0110);
        chk("fwd_partial_conf", ld_conflict, 1);
        chk("fwd_partial_hit", ld_fwd_hit, 0);
        ld_valid = 1'b0;

        bus_wr_ack = 1'b1;
        tick();
        chk("arst_pre_req", bus_wr_req, 1);
        chk("arst_pre_count", count, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", bus_wr_req, 0);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        bus_wr_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push(32'h600, 32'hCAFEF00D, 4'b0101);
        chk("post_req", bus_wr_req, 1);
        chk("post_addr", bus_addr, 32'h600);
        chk("post_data", bus_wdata, 32'hCAFEF00D);
        chk("post_sel", bus_sel, 4'b0101);
        bus_wr_ack = 1'b1;
        tick();
        bus_wr_ack = 1'b0;
        push(32'h70B, 32'h12345678, 4'b1000);
        chk("align_addr", bus_addr, 32'h708);
        chk("align_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
